hand_gesture_detect: RTL and testbench
======================================

// Module: hand_gesture_detect
// PURPOSE
//   Front end of the LED control path. Turns two raw hand-proximity sensor inputs into a clean gesture code
//   for the LED state machine's 2-bit hand input. Steps: synchronise, debounce, qualify a minimum hold time,
//   then emit exactly one single-cycle code per gesture. The LED FSM advances on every cycle that hand==2'b11,
//   so more than one pulse per gesture is a functional bug.
// PARAMETERS
//   DEB_CYCLES   1_000_000   cycles a synchronised input must be stable before the debounced level flips (>=2)
//   HOLD_CYCLES  20_000_000  cycles a gesture must be held in ARM before its code is emitted (>=2)
//   CNT_W        29          width of the debounce and hold counters; must hold max(DEB_CYCLES,HOLD_CYCLES)
// PORTS
//   clk     in   1      system clock
//   rst_n   in   1      synchronous reset, active low
//   sens_l  in   1      raw left sensor, asynchronous, 1 = hand present
//   sens_r  in   1      raw right sensor, asynchronous, 1 = hand present
//   hand    out  2      gesture pulse: [1]=left, [0]=right; 00 = none; held for exactly one cycle per gesture
//   busy    out  1      1 whenever the FSM is not in IDLE
// BEHAVIOUR
//   Reset (rst_n==0 at a clk edge)
//     - Clears sync flops, debounced levels, counters, mask, hand=00, busy=0; state=IDLE.
//     - A reset mid-gesture abandons the gesture and emits no pulse.
//   Synchroniser
//     - Two-flop chain per input, reset to 0.
//     - A raw level sampled at edge k appears on sync2 after edge k+1.
//   Debounce (one per channel)
//     - If sync2 != deb: increment the counter. When the counter reaches DEB_CYCLES-1 with a mismatch still
//       present, flip deb and clear the counter.
//     - If sync2 == deb: clear the counter.
//     - Result: deb changes after edge k+1+DEB_CYCLES. A glitch shorter than DEB_CYCLES cycles never changes deb.
//   FSM (states IDLE, ARM, RELEASE; all outputs registered)
//     - IDLE: if deb_l|deb_r, go to ARM with mask={deb_l,deb_r} and hold_cnt=0.
//     - ARM, both deb low: go to IDLE with no pulse (too short).
//     - ARM, otherwise: mask |= {deb_l,deb_r} (staggered arrival counts as both) and hold_cnt++.
//       When hold_cnt==HOLD_CYCLES-1, register hand=mask for one cycle and go to RELEASE.
//     - RELEASE: hand=00. Stay until deb_l==0 && deb_r==0, then go to IDLE. Holding never repeats the pulse.
//     - Releasing a sensor in ARM while the other is still high does not remove its bit from mask.
//   Latency
//     - Raw rise sampled at edge 0 enters ARM after edge DEB_CYCLES+2.
//     - hand is valid after edge DEB_CYCLES+HOLD_CYCLES+2, for one cycle.
//   busy
//     - Registered: 1 in ARM and RELEASE, 0 in IDLE.
//     - busy may be 1 on the cycle hand is valid.
//   Counters
//     - Saturate-free: cleared before overflow by construction when CNT_W is sized per PARAMETERS.
// TESTING (DEB_CYCLES=4, HOLD_CYCLES=10)
//   1. Reset: sensors high, rst_n low 5 cycles -> hand=00, busy=0 throughout.
//      After release, a normal gesture follows (pulse 16 edges after rst_n rises).
//   2. Glitch: sens_l high 3 cycles then low -> deb_l never rises, busy stays 0, hand stays 00.
//   3. Both: sens_l=sens_r=1 from edge 0 for 40 cycles -> hand=11 after edge 16 for exactly one cycle, busy=1.
//      After both drop, busy returns to 0 by edge 40+4+2+1.
//   4. Single/staggered: sens_l only -> single pulse hand=10.
//      sens_l at edge 0, sens_r at edge 5 (both held) -> single pulse hand=11.
//   5. Short press: both high 8 cycles -> ARM entered, returns to IDLE, hand never non-zero.
//   6. Sequence: four 30-cycle both-presses separated by 20-cycle gaps -> exactly four hand=11 pulses.
//      One 200-cycle hold -> exactly one pulse. Assert rst_n low at edge 12 of a press -> no pulse.

Source files
------------

// File: rtl/hand_gesture_detect.sv
// hand_gesture_detect
//   Conditions two raw hand-proximity sensors into a one-shot gesture code for
//   the LED state machine. Each input is synchronised, debounced and, once
//   either channel is seen, must be held for HOLD_CYCLES before a single-cycle
//   code is emitted. Further pulses are suppressed until both hands are gone.
// Ports
//   clk     system clock
//   rst_n   synchronous reset, active low
//   sens_l  raw left sensor (asynchronous), 1 = hand present
//   sens_r  raw right sensor (asynchronous), 1 = hand present
//   hand    gesture pulse, [1]=left [0]=right, valid for exactly one cycle
//   busy    high whenever a gesture is being tracked or released
module hand_gesture_detect #(
   parameter int unsigned DEB_CYCLES  = 1_000_000,
   parameter int unsigned HOLD_CYCLES = 20_000_000,
   parameter int unsigned CNT_W       = 29
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sens_l,
   input  logic       sens_r,
   output logic [1:0] hand,
   output logic       busy
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARM     = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

   logic             sync1_l_q, sync2_l_q, sync1_r_q, sync2_r_q;
   logic             deb_l_q, deb_l_d, deb_r_q, deb_r_d;
   logic [CNT_W-1:0] deb_cnt_l_q, deb_cnt_l_d, deb_cnt_r_q, deb_cnt_r_d;
   logic [1:0]       state_q, state_d;
   logic [1:0]       mask_q, mask_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [1:0]       hand_q, hand_d;
   logic             busy_q, busy_d;
   logic             any_deb;

   assign any_deb = deb_l_q | deb_r_q;

   // Debounce: the level only flips after DEB_CYCLES consecutive mismatches;
   // any agreeing sample restarts the count.
   always_comb begin
      deb_l_d     = deb_l_q;
      deb_cnt_l_d = '0;
      if (sync2_l_q != deb_l_q) begin
         if (deb_cnt_l_q == DEB_LAST) begin
            deb_l_d = ~deb_l_q;
         end else begin
            deb_cnt_l_d = deb_cnt_l_q + CNT_W'(1);
         end
      end

      deb_r_d     = deb_r_q;
      deb_cnt_r_d = '0;
      if (sync2_r_q != deb_r_q) begin
         if (deb_cnt_r_q == DEB_LAST) begin
            deb_r_d = ~deb_r_q;
         end else begin
            deb_cnt_r_d = deb_cnt_r_q + CNT_W'(1);
         end
      end
   end

   // Gesture tracking. The mask only accumulates while armed, so a hand that
   // leaves early still contributes its bit; the emitted code includes any
   // hand that arrives on the final hold cycle.
   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      hold_d  = hold_q;
      hand_d  = '0;
      case (state_q)
         ST_IDLE: begin
            if (any_deb) begin
               state_d = ST_ARM;
               mask_d  = {deb_l_q, deb_r_q};
               hold_d  = '0;
            end
         end
         ST_ARM: begin
            if (!any_deb) begin
               state_d = ST_IDLE;
            end else begin
               mask_d = mask_q | {deb_l_q, deb_r_q};
               hold_d = hold_q + CNT_W'(1);
               if (hold_q == HOLD_LAST) begin
                  hand_d  = mask_d;
                  state_d = ST_RELEASE;
               end
            end
         end
         ST_RELEASE: begin
            if (!any_deb) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_l_q   <= 1'b0;
         sync2_l_q   <= 1'b0;
         sync1_r_q   <= 1'b0;
         sync2_r_q   <= 1'b0;
         deb_l_q     <= 1'b0;
         deb_r_q     <= 1'b0;
         deb_cnt_l_q <= '0;
         deb_cnt_r_q <= '0;
         state_q     <= ST_IDLE;
         mask_q      <= '0;
         hold_q      <= '0;
         hand_q      <= '0;
         busy_q      <= 1'b0;
      end else begin
         sync1_l_q   <= sens_l;
         sync2_l_q   <= sync1_l_q;
         sync1_r_q   <= sens_r;
         sync2_r_q   <= sync1_r_q;
         deb_l_q     <= deb_l_d;
         deb_r_q     <= deb_r_d;
         deb_cnt_l_q <= deb_cnt_l_d;
         deb_cnt_r_q <= deb_cnt_r_d;
         state_q     <= state_d;
         mask_q      <= mask_d;
         hold_q      <= hold_d;
         hand_q      <= hand_d;
         busy_q      <= busy_d;
      end
   end

   assign hand = hand_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_hand_gesture_detect.sv
// tb_hand_gesture_detect
//   Drives directed gesture scenarios followed by random sensor activity and
//   compares hand/busy every cycle against a timeline-based reference model.
module tb_hand_gesture_detect;

   localparam int DEB  = 4;
   localparam int HOLD = 10;

   logic       clk;
   logic       rst_n;
   logic       sens_l;
   logic       sens_r;
   logic [1:0] hand;
   logic       busy;

   hand_gesture_detect #(
      .DEB_CYCLES (DEB),
      .HOLD_CYCLES(HOLD),
      .CNT_W      (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sens_l(sens_l),
      .sens_r(sens_r),
      .hand  (hand),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // hist_x[0] is the raw sample of the previous edge, hist_x[1] the one
   // before it, i.e. the value the synchroniser presents at the current edge.
   int   cyc = 0;
   logic hist_l [0:DEB];
   logic hist_r [0:DEB];
   logic m_deb_l = 1'b0, m_deb_r = 1'b0;
   logic m_active = 1'b0, m_fired = 1'b0;
   logic [1:0] m_mask = 2'b00;
   int   m_arm_cyc = 0;
   logic [1:0] exp_hand = 2'b00;
   logic       exp_busy = 1'b0;

   initial begin
      for (int i = 0; i <= DEB; i++) begin
         hist_l[i] = 1'b0;
         hist_r[i] = 1'b0;
      end
   end

   always @(posedge clk) begin : model
      logic       fl, fr, act, fired;
      logic [1:0] msk, h;
      int         arm;
      cyc <= cyc + 1;
      if (!rst_n) begin
         for (int i = 0; i <= DEB; i++) begin
            hist_l[i] <= 1'b0;
            hist_r[i] <= 1'b0;
         end
         m_deb_l  <= 1'b0;
         m_deb_r  <= 1'b0;
         m_active <= 1'b0;
         m_fired  <= 1'b0;
         m_mask   <= 2'b00;
         exp_hand <= 2'b00;
         exp_busy <= 1'b0;
      end else begin
         // a level flips once the last DEB synchronised samples all disagree
         fl = 1'b1;
         fr = 1'b1;
         for (int i = 0; i < DEB; i++) begin
            if (hist_l[1+i] == m_deb_l) fl = 1'b0;
            if (hist_r[1+i] == m_deb_r) fr = 1'b0;
         end
         // gesture timeline: armed at edge arm, fires at edge arm+HOLD
         act   = m_active;
         fired = m_fired;
         msk   = m_mask;
         arm   = m_arm_cyc;
         h     = 2'b00;
         if (!act) begin
            if (m_deb_l | m_deb_r) begin
               act   = 1'b1;
               fired = 1'b0;
               arm   = cyc;
               msk   = {m_deb_l, m_deb_r};
            end
         end else if (!(m_deb_l | m_deb_r)) begin
            act = 1'b0;
         end else if (!fired) begin
            msk = msk | {m_deb_l, m_deb_r};
            if (cyc == arm + HOLD) begin
               h     = msk;
               fired = 1'b1;
            end
         end
         m_active  <= act;
         m_fired   <= fired;
         m_mask    <= msk;
         m_arm_cyc <= arm;
         exp_hand  <= h;
         exp_busy  <= act;
         m_deb_l   <= fl ? ~m_deb_l : m_deb_l;
         m_deb_r   <= fr ? ~m_deb_r : m_deb_r;
         for (int i = DEB; i >= 1; i--) begin
            hist_l[i] <= hist_l[i-1];
            hist_r[i] <= hist_r[i-1];
         end
         hist_l[0] <= sens_l;
         hist_r[0] <= sens_r;
      end
   end

   // ---------------- checking ----------------
   int         checks = 0;
   int         errors = 0;
   int         pulses = 0;
   int         busy_cycles = 0;
   int         last_pulse_cyc = -1;
   logic [1:0] last_pulse_val = 2'b00;

   task automatic check_eq(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic compare_cycle();
      checks++;
      if (hand !== exp_hand) begin
         errors++;
         $display("FAIL hand cycle %0d: got %b expected %b", cyc, hand, exp_hand);
      end
      checks++;
      if (busy !== exp_busy) begin
         errors++;
         $display("FAIL busy cycle %0d: got %b expected %b", cyc, busy, exp_busy);
      end
      if (hand != 2'b00) begin
         pulses++;
         last_pulse_cyc = cyc;
         last_pulse_val = hand;
      end
      if (busy == 1'b1) busy_cycles++;
   endtask

   task automatic run(input logic l, input logic r, input int n);
      sens_l = l;
      sens_r = r;
      repeat (n) begin
         @(posedge clk);
         #2;
         compare_cycle();
      end
   endtask

   int start, p0, b0;

   initial begin
      rst_n  = 1'b0;
      sens_l = 1'b0;
      sens_r = 1'b0;

      // 1: reset with both sensors high, then a normal gesture
      b0 = busy_cycles;
      p0 = pulses;
      run(1'b1, 1'b1, 5);
      check_eq("reset_hand", int'(hand), 0);
      check_eq("reset_busy", int'(busy), 0);
      check_eq("reset_busy_never", busy_cycles - b0, 0);
      check_eq("reset_no_pulse", pulses - p0, 0);
      rst_n = 1'b1;
      start = cyc + 1;
      p0 = pulses;
      run(1'b1, 1'b1, 30);
      check_eq("post_reset_count", pulses - p0, 1);
      check_eq("post_reset_time", last_pulse_cyc - start, 16);
      check_eq("post_reset_val", int'(last_pulse_val), 3);
      run(1'b0, 1'b0, 15);

      // 2: glitch shorter than the debounce window
      b0 = busy_cycles;
      p0 = pulses;
      run(1'b1, 1'b0, 3);
      run(1'b0, 1'b0, 15);
      check_eq("glitch_busy", busy_cycles - b0, 0);
      check_eq("glitch_pulse", pulses - p0, 0);

      // 3: both hands for 40 cycles
      start = cyc + 1;
      p0 = pulses;
      b0 = busy_cycles;
      run(1'b1, 1'b1, 40);
      check_eq("both_count", pulses - p0, 1);
      check_eq("both_time", last_pulse_cyc - start, 16);
      check_eq("both_val", int'(last_pulse_val), 3);
      check_eq("both_busy_seen", int'(busy_cycles - b0 > 0), 1);
      run(1'b0, 1'b0, 7);
      check_eq("both_release_busy", int'(busy), 0);
      run(1'b0, 1'b0, 5);

      // 4: left only, then staggered arrival
      start = cyc + 1;
      p0 = pulses;
      run(1'b1, 1'b0, 30);
      check_eq("left_count", pulses - p0, 1);
      check_eq("left_time", last_pulse_cyc - start, 16);
      check_eq("left_val", int'(last_pulse_val), 2);
      run(1'b0, 1'b0, 12);
      start = cyc + 1;
      p0 = pulses;
      run(1'b1, 1'b0, 5);
      run(1'b1, 1'b1, 30);
      check_eq("stagger_count", pulses - p0, 1);
      check_eq("stagger_time", last_pulse_cyc - start, 16);
      check_eq("stagger_val", int'(last_pulse_val), 3);
      run(1'b0, 1'b0, 12);

      // 5: press too short to qualify
      b0 = busy_cycles;
      p0 = pulses;
      run(1'b1, 1'b1, 8);
      run(1'b0, 1'b0, 15);
      check_eq("short_armed", int'(busy_cycles - b0 > 0), 1);
      check_eq("short_pulse", pulses - p0, 0);

      // 6: repeated presses, a long hold, and reset mid-press
      p0 = pulses;
      repeat (4) begin
         run(1'b1, 1'b1, 30);
         run(1'b0, 1'b0, 20);
      end
      check_eq("seq_count", pulses - p0, 4);
      p0 = pulses;
      run(1'b1, 1'b1, 200);
      run(1'b0, 1'b0, 15);
      check_eq("long_hold_count", pulses - p0, 1);
      p0 = pulses;
      run(1'b1, 1'b1, 12);
      rst_n = 1'b0;
      run(1'b1, 1'b1, 3);
      run(1'b0, 1'b0, 2);
      rst_n = 1'b1;
      run(1'b0, 1'b0, 20);
      check_eq("reset_mid_press", pulses - p0, 0);

      // random activity, occasional reset
      repeat (150) begin
         rst_n = ($urandom_range(0, 24) != 0);
         run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(1, 30)));
      end
      rst_n = 1'b1;
      run(1'b0, 1'b0, 20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
